// File: rtl/red_pitaya_iq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : red_pitaya_iq_pkg
// Description : Shared widths and saturation constants for the IQ blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package red_pitaya_iq_pkg;

    localparam int NLOG2_W = 5;

    function automatic int pbits(input int inbits, input int sinbits);
        return inbits + sinbits;
    endfunction

    function automatic int accbits(input int pbits_w, input int nlog2max);
        return pbits_w + nlog2max;
    endfunction

    function automatic longint sat_maxpos(input int outbits);
        return (longint'(1) <<< (outbits - 1)) - 1;
    endfunction

    function automatic longint sat_maxneg(input int outbits);
        return -(longint'(1) <<< (outbits - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/red_pitaya_iq_boxcar.sv
`default_nettype none
// ============================================================================
// Module      : red_pitaya_iq_boxcar
// Description : One quadrature: accumulate, shift, slice and saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module red_pitaya_iq_boxcar
    import red_pitaya_iq_pkg::*;
#(
    parameter int PBITS   = 28,
    parameter int ACCBITS = 44,
    parameter int OUTBITS = 18
) (
    input  logic                       clk,
    input  logic                       i_rstn,
    input  logic                       i_en,
    input  logic                       i_start,
    input  logic                       i_last,
    input  logic [NLOG2_W-1:0]         i_n,
    input  logic signed [PBITS-1:0]    i_p,
    output logic signed [OUTBITS-1:0]  o_data,
    output logic                       o_ovf
);

    localparam logic signed [OUTBITS-1:0] c_MAXPOS = OUTBITS'(sat_maxpos(OUTBITS));
    localparam logic signed [OUTBITS-1:0] c_MAXNEG = OUTBITS'(sat_maxneg(OUTBITS));

    logic signed [ACCBITS-1:0] r_acc;
    logic signed [OUTBITS-1:0] r_data;
    logic                      r_ovf;

    logic signed [ACCBITS-1:0] w_p_ext;
    logic signed [ACCBITS-1:0] w_sum;
    logic signed [ACCBITS-1:0] w_avg;
    logic        [OUTBITS-1:0] w_slice;
    logic                      w_ovf;
    logic signed [OUTBITS-1:0] w_data;
    logic                      w_unused_hi;

    assign w_p_ext = {{(ACCBITS-PBITS){i_p[PBITS-1]}}, i_p};
    assign w_sum   = i_start ? w_p_ext : (r_acc + w_p_ext);
    assign w_avg   = w_sum >>> i_n;

    // The window average always fits in PBITS; only those bits carry data.
    assign w_unused_hi = ^w_avg[ACCBITS-1:PBITS];

    generate
        if (OUTBITS == PBITS - 1) begin : g_slice_exact
            assign w_slice = w_avg[PBITS-2:0];
        end else if (OUTBITS < PBITS - 1) begin : g_slice_trunc
            logic w_unused_lo;
            assign w_slice     = w_avg[PBITS-2 -: OUTBITS];
            assign w_unused_lo = ^w_avg[PBITS-OUTBITS-2:0];
        end else begin : g_slice_pad
            assign w_slice = {w_avg[PBITS-2:0], {(OUTBITS-PBITS+1){1'b0}}};
        end
    endgenerate

    assign w_ovf  = w_avg[PBITS-1] ^ w_avg[PBITS-2];
    assign w_data = !w_ovf ? $signed(w_slice)
                  : (w_avg[PBITS-1] ? c_MAXNEG : c_MAXPOS);

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_acc  <= '0;
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else if (!i_en) begin
            r_acc <= '0;
        end else if (i_last) begin
            r_acc  <= '0;
            r_data <= w_data;
            r_ovf  <= w_ovf;
        end else begin
            r_acc <= w_sum;
        end
    end

    assign o_data = r_data;
    assign o_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/red_pitaya_iq_demodulator_block.sv
`default_nettype none
// ============================================================================
// Module      : red_pitaya_iq_demodulator_block
// Description : IQ mixer plus 2^N boxcar average with saturated I/Q output.
// Revision    : 1.0 - initial release
// ============================================================================
module red_pitaya_iq_demodulator_block
    import red_pitaya_iq_pkg::*;
#(
    parameter int INBITS   = 14,
    parameter int SINBITS  = 14,
    parameter int OUTBITS  = 18,
    parameter int NLOG2MAX = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic signed [INBITS-1:0]   signal_i,
    input  logic signed [SINBITS-1:0]  sin,
    input  logic signed [SINBITS-1:0]  cos,
    input  logic                       enable_i,
    input  logic [NLOG2_W-1:0]         nlog2_i,
    output logic signed [OUTBITS-1:0]  signal1_o,
    output logic signed [OUTBITS-1:0]  signal2_o,
    output logic                       valid_o,
    output logic                       overflow_o
);

    localparam int c_PBITS   = pbits(INBITS, SINBITS);
    localparam int c_ACCBITS = accbits(c_PBITS, NLOG2MAX);
    localparam logic [NLOG2_W-1:0] c_NMAX = NLOG2_W'(NLOG2MAX);

    logic signed [c_PBITS-1:0] r_p1;
    logic signed [c_PBITS-1:0] r_p2;
    logic                      r_v1;
    logic [NLOG2MAX-1:0]       r_cnt;
    logic [NLOG2_W-1:0]        r_n;
    logic                      r_valid;

    logic signed [c_PBITS-1:0] w_sig_ext;
    logic signed [c_PBITS-1:0] w_sin_ext;
    logic signed [c_PBITS-1:0] w_cos_ext;
    logic [NLOG2_W-1:0]        w_n_clamp;
    logic [NLOG2_W-1:0]        w_n_eff;
    logic                      w_start;
    logic [NLOG2MAX:0]         w_cnt_inc;
    logic [NLOG2MAX:0]         w_span;
    logic                      w_win_end;
    logic                      w_ovf1;
    logic                      w_ovf2;

    assign w_sig_ext = {{SINBITS{signal_i[INBITS-1]}}, signal_i};
    assign w_sin_ext = {{INBITS{sin[SINBITS-1]}}, sin};
    assign w_cos_ext = {{INBITS{cos[SINBITS-1]}}, cos};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_p1 <= '0;
            r_p2 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_p1 <= w_sig_ext * w_sin_ext;
            r_p2 <= w_sig_ext * w_cos_ext;
            r_v1 <= enable_i;
        end
    end

    // At a window start the freshly clamped exponent already governs that window.
    assign w_n_clamp = (nlog2_i > c_NMAX) ? c_NMAX : nlog2_i;
    assign w_start   = (r_cnt == '0);
    assign w_n_eff   = w_start ? w_n_clamp : r_n;
    assign w_cnt_inc = {1'b0, r_cnt} + (NLOG2MAX+1)'(1);
    assign w_span    = (NLOG2MAX+1)'(1) << w_n_eff;
    assign w_win_end = r_v1 && (w_cnt_inc == w_span);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt   <= '0;
            r_n     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_win_end;
            if (!r_v1 || w_win_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_v1 && w_start) begin
                r_n <= w_n_clamp;
            end
        end
    end

    red_pitaya_iq_boxcar #(
        .PBITS   (c_PBITS),
        .ACCBITS (c_ACCBITS),
        .OUTBITS (OUTBITS)
    ) u_box_i (
        .clk     (clk_i),
        .i_rstn  (rstn_i),
        .i_en    (r_v1),
        .i_start (w_start),
        .i_last  (w_win_end),
        .i_n     (w_n_eff),
        .i_p     (r_p1),
        .o_data  (signal1_o),
        .o_ovf   (w_ovf1)
    );

    red_pitaya_iq_boxcar #(
        .PBITS   (c_PBITS),
        .ACCBITS (c_ACCBITS),
        .OUTBITS (OUTBITS)
    ) u_box_q (
        .clk     (clk_i),
        .i_rstn  (rstn_i),
        .i_en    (r_v1),
        .i_start (w_start),
        .i_last  (w_win_end),
        .i_n     (w_n_eff),
        .i_p     (r_p2),
        .o_data  (signal2_o),
        .o_ovf   (w_ovf2)
    );

    assign valid_o    = r_valid;
    assign overflow_o = w_ovf1 | w_ovf2;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_iq_demodulator_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_red_pitaya_iq_demodulator_block
// Description : Randomized bench with a window-level averaging reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_red_pitaya_iq_demodulator_block;

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic signed [13:0] signal_i;
    logic signed [13:0] sin;
    logic signed [13:0] cos;
    logic               enable_i;
    logic [4:0]         nlog2_i;
    logic signed [17:0] signal1_o;
    logic signed [17:0] signal2_o;
    logic               valid_o;
    logic               overflow_o;

    red_pitaya_iq_demodulator_block dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .signal_i   (signal_i),
        .sin        (sin),
        .cos        (cos),
        .enable_i   (enable_i),
        .nlog2_i    (nlog2_i),
        .signal1_o  (signal1_o),
        .signal2_o  (signal2_o),
        .valid_o    (valid_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;
    int n_valid = 0;

    // Reference model: samples of the open window, the window exponent and
    // the expected output word.
    longint q1[$];
    longint q2[$];
    int     win_n;
    logic   prev_en;
    longint prev_p1, prev_p2;
    logic   exp_valid;
    longint exp_s1, exp_s2;
    logic   exp_ovf;

    function automatic void quad_result(input longint sum, input int n,
                                        output longint res, output logic ovf);
        longint avg;
        avg = sum >>> n;
        if (avg > (longint'(1) <<< 26) - 1) begin
            res = 131071; ovf = 1'b1;
        end else if (avg < -(longint'(1) <<< 26)) begin
            res = -131072; ovf = 1'b1;
        end else begin
            res = avg >>> 9; ovf = 1'b0;
        end
    endfunction

    task automatic check(input string tag, input longint obs, input longint expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, longint'(valid_o), longint'(exp_valid));
        check({tag, ".sig1"},  longint'(signal1_o), exp_s1);
        check({tag, ".sig2"},  longint'(signal2_o), exp_s2);
        check({tag, ".ovf"},   longint'(overflow_o), longint'(exp_ovf));
    endtask

    task automatic model_clear();
        q1.delete(); q2.delete();
        prev_en = 1'b0; prev_p1 = 0; prev_p2 = 0;
        exp_valid = 1'b0; exp_s1 = 0; exp_s2 = 0; exp_ovf = 1'b0;
        win_n = 0;
    endtask

    task automatic step(input string tag, input int sg, input int s, input int c,
                        input logic en, input int nl);
        longint sum1, sum2, r1, r2;
        logic o1, o2;
        @(negedge clk_i);
        signal_i = 14'(sg); sin = 14'(s); cos = 14'(c);
        enable_i = en; nlog2_i = 5'(nl);
        // The previous sample's product reaches the averager this cycle.
        exp_valid = 1'b0;
        if (prev_en) begin
            if (q1.size() == 0) win_n = (nlog2_i > 5'd16) ? 16 : int'(nlog2_i);
            q1.push_back(prev_p1);
            q2.push_back(prev_p2);
            if (q1.size() == (1 << win_n)) begin
                sum1 = 0; sum2 = 0;
                foreach (q1[i]) begin sum1 += q1[i]; sum2 += q2[i]; end
                quad_result(sum1, win_n, r1, o1);
                quad_result(sum2, win_n, r2, o2);
                exp_valid = 1'b1; exp_s1 = r1; exp_s2 = r2; exp_ovf = o1 | o2;
                q1.delete(); q2.delete();
            end
        end else begin
            q1.delete(); q2.delete();
        end
        prev_en = en;
        prev_p1 = longint'(signal_i) * longint'(sin);
        prev_p2 = longint'(signal_i) * longint'(cos);
        @(posedge clk_i);
        #1;
        if (exp_valid) n_valid++;
        check_all(tag);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_i);
        rstn_i = 1'b0;
        model_clear();
        #1;
        check_all("reset_async");
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            signal_i = 14'($urandom); sin = 14'($urandom); cos = 14'($urandom);
            enable_i = 1'($urandom); nlog2_i = 5'($urandom);
            @(posedge clk_i);
            #1;
            check_all("reset_hold");
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    function automatic int rnd14();
        return int'($signed(14'($urandom)));
    endfunction

    initial begin
        int nl, vcount;
        rstn_i = 1'b0; signal_i = '0; sin = '0; cos = '0; enable_i = 1'b0; nlog2_i = '0;
        model_clear();

        do_reset(4);

        // Enabled-off traffic must never produce a strobe.
        for (int i = 0; i < 20; i++) step("idle", rnd14(), rnd14(), rnd14(), 1'b0, $urandom_range(0, 4));

        // n=0: one result per sample.
        for (int i = 0; i < 8; i++) step("n0", 4096, 8191, 0, 1'b1, 0);
        check("n0_sig1_direct", longint'(signal1_o), 65528);
        step("gap", 0, 0, 0, 1'b0, 2);

        // n=2: 1000..4000 repeating, average 2500.
        for (int w = 0; w < 4; w++)
            for (int k = 1; k <= 4; k++) step("n2", 1000 * k, 8191, -8191, 1'b1, 2);
        step("n2_tail", 0, 0, 0, 1'b0, 2);
        check("n2_sig1_direct", longint'(signal1_o), 39995);
        check("n2_sig2_direct", longint'(signal2_o), -39996);
        step("gap", 0, 0, 0, 1'b0, 0);

        // Saturation, then recovery with an in-range sample.
        step("sat", -8192, -8192, 8191, 1'b1, 0);
        step("sat2", 100, 100, 100, 1'b1, 0);
        check("sat_sig1_direct", longint'(signal1_o), 131071);
        check("sat_sig2_direct", longint'(signal2_o), -131056);
        check("sat_ovf_direct", longint'(overflow_o), 1);
        step("unsat", 0, 0, 0, 1'b0, 0);
        check("unsat_ovf_direct", longint'(overflow_o), 0);

        // Exponent change mid-window: the open n=3 window still takes 8 samples.
        step("wchg", rnd14(), rnd14(), rnd14(), 1'b1, 3);
        step("wchg", rnd14(), rnd14(), rnd14(), 1'b1, 3);
        for (int i = 0; i < 18; i++) step("wchg", rnd14(), rnd14(), rnd14(), 1'b1, 1);
        step("gap", 0, 0, 0, 1'b0, 2);

        // Enable drop discards the partial window.
        for (int i = 0; i < 3; i++) step("drop", rnd14(), rnd14(), rnd14(), 1'b1, 2);
        for (int i = 0; i < 3; i++) step("drop_off", rnd14(), rnd14(), rnd14(), 1'b0, 2);
        for (int i = 0; i < 10; i++) step("reen", rnd14(), rnd14(), rnd14(), 1'b1, 2);

        // Randomized traffic with occasional exponent and enable changes.
        nl = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) nl = $urandom_range(0, 4);
            step("rand", rnd14(), rnd14(), rnd14(), ($urandom_range(0, 19) != 0), nl);
        end

        // Reset in the middle of a window, then a fresh window.
        for (int i = 0; i < 3; i++) step("pre_rst", rnd14(), rnd14(), rnd14(), 1'b1, 3);
        do_reset(2);
        for (int i = 0; i < 12; i++) step("post_rst", rnd14(), rnd14(), rnd14(), 1'b1, 3);
        step("gap", 0, 0, 0, 1'b0, 31);

        // Exponent 31 clamps to 16: a single strobe after 65536 samples.
        vcount = n_valid;
        for (int i = 0; i < 65536 + 3; i++) step("clamp", rnd14(), rnd14(), rnd14(), 1'b1, 31);
        check("clamp_valid_count", longint'(n_valid - vcount), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
